// File: rtl/pipe_stage_skid.sv
// pipe_stage_skid: a parametrised pipeline stage register.
// It carries opaque control and data bundles between stages with a valid/ready handshake.
// A two-entry skid buffer gives full throughput while in_ready comes straight from a register.
// A synchronous flush empties the stage, and saturating counters record stall, bubble and flush cycles.
module pipe_stage_skid #(
    parameter int                DATA_W   = 128,
    parameter int                CTRL_W   = 16,
    parameter logic [CTRL_W-1:0] CTRL_NOP = {CTRL_W{1'b0}},
    parameter int                CNT_W    = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [CTRL_W-1:0] in_ctrl,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [DATA_W-1:0] out_data,
    input  logic              cnt_clear,
    output logic [CNT_W-1:0]  stall_cnt,
    output logic [CNT_W-1:0]  bubble_cnt,
    output logic [CNT_W-1:0]  flush_cnt
);

    // The state encoding is {skid_v, main_v}. Encoding 2'b10 is never entered.
    typedef enum logic [1:0] {
        EMPTY = 2'b00,
        ONE   = 2'b01,
        TWO   = 2'b11
    } state_t;

    state_t              state_r;
    logic                in_ready_r;
    logic [CTRL_W-1:0]   main_ctrl_r;
    logic [DATA_W-1:0]   main_data_r;
    logic [CTRL_W-1:0]   skid_ctrl_r;
    logic [DATA_W-1:0]   skid_data_r;
    logic [CNT_W-1:0]    stall_cnt_r;
    logic [CNT_W-1:0]    bubble_cnt_r;
    logic [CNT_W-1:0]    flush_cnt_r;

    logic                main_v_s;
    logic                in_fire_s;
    logic                out_fire_s;

    // Increment a counter by one, holding it at the all-ones value.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] value);
        if (value == {CNT_W{1'b1}}) begin
            return value;
        end else begin
            return value + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    endfunction

    // Decode the handshakes from the registered state.
    always_comb begin
        main_v_s   = state_r[0];
        in_fire_s  = in_valid & in_ready_r;
        out_fire_s = main_v_s & out_ready;
    end

    // Drive the outputs from the main entry. Nothing held means NOP control and zero data.
    always_comb begin
        in_ready  = in_ready_r;
        out_valid = main_v_s;
        if (main_v_s) begin
            out_ctrl = main_ctrl_r;
            out_data = main_data_r;
        end else begin
            out_ctrl = CTRL_NOP;
            out_data = {DATA_W{1'b0}};
        end
    end

    // Stage FSM and storage. Reset has priority over flush, and flush has priority over the handshake.
    // in_ready_r is the inverse of the next skid_v.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r     <= EMPTY;
            in_ready_r  <= 1'b1;
            main_ctrl_r <= CTRL_NOP;
            main_data_r <= {DATA_W{1'b0}};
            skid_ctrl_r <= CTRL_NOP;
            skid_data_r <= {DATA_W{1'b0}};
        end else if (flush) begin
            state_r    <= EMPTY;
            in_ready_r <= 1'b1;
        end else begin
            case (state_r)
                EMPTY: begin
                    in_ready_r <= 1'b1;
                    if (in_fire_s) begin
                        main_ctrl_r <= in_ctrl;
                        main_data_r <= in_data;
                        state_r     <= ONE;
                    end
                end
                ONE: begin
                    if (in_fire_s && out_fire_s) begin
                        main_ctrl_r <= in_ctrl;
                        main_data_r <= in_data;
                        in_ready_r  <= 1'b1;
                    end else if (in_fire_s) begin
                        skid_ctrl_r <= in_ctrl;
                        skid_data_r <= in_data;
                        state_r     <= TWO;
                        in_ready_r  <= 1'b0;
                    end else if (out_fire_s) begin
                        state_r    <= EMPTY;
                        in_ready_r <= 1'b1;
                    end else begin
                        in_ready_r <= 1'b1;
                    end
                end
                TWO: begin
                    if (out_fire_s) begin
                        main_ctrl_r <= skid_ctrl_r;
                        main_data_r <= skid_data_r;
                        state_r     <= ONE;
                        in_ready_r  <= 1'b1;
                    end else begin
                        in_ready_r <= 1'b0;
                    end
                end
                default: begin
                    state_r    <= EMPTY;
                    in_ready_r <= 1'b1;
                end
            endcase
        end
    end

    // Performance counters. A clear wins over an increment. The stall and bubble conditions ignore flush.
    always_ff @(posedge clk) begin
        if (reset || cnt_clear) begin
            stall_cnt_r  <= {CNT_W{1'b0}};
            bubble_cnt_r <= {CNT_W{1'b0}};
            flush_cnt_r  <= {CNT_W{1'b0}};
        end else begin
            if (main_v_s && !out_ready) begin
                stall_cnt_r <= sat_inc(stall_cnt_r);
            end
            if (!main_v_s && out_ready) begin
                bubble_cnt_r <= sat_inc(bubble_cnt_r);
            end
            if (flush) begin
                flush_cnt_r <= sat_inc(flush_cnt_r);
            end
        end
    end

    assign stall_cnt  = stall_cnt_r;
    assign bubble_cnt = bubble_cnt_r;
    assign flush_cnt  = flush_cnt_r;

endmodule

// File: tb/tb_pipe_stage_skid.sv
// Testbench for pipe_stage_skid.
// A scoreboard queue receives each accepted instruction and is compared against every instruction the stage hands downstream.
// Directed checks cover the handshake, flush, reset and counter cases.
module tb_pipe_stage_skid;

    localparam int                DATA_W   = 16;
    localparam int                CTRL_W   = 8;
    localparam int                CNT_W    = 4;
    localparam logic [CTRL_W-1:0] CTRL_NOP = 8'hA5;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic              flush = 1'b0;
    logic              in_valid = 1'b0;
    logic              in_ready;
    logic [CTRL_W-1:0] in_ctrl = 8'h00;
    logic [DATA_W-1:0] in_data = 16'h0000;
    logic              out_valid;
    logic              out_ready = 1'b0;
    logic [CTRL_W-1:0] out_ctrl;
    logic [DATA_W-1:0] out_data;
    logic              cnt_clear = 1'b0;
    logic [CNT_W-1:0]  stall_cnt;
    logic [CNT_W-1:0]  bubble_cnt;
    logic [CNT_W-1:0]  flush_cnt;

    int n_cmp = 0;
    int n_bad = 0;
    logic [23:0] sb_q[$];

    pipe_stage_skid #(
        .DATA_W(DATA_W), .CTRL_W(CTRL_W), .CTRL_NOP(CTRL_NOP), .CNT_W(CNT_W)
    ) dut (
        .clk(clk), .reset(reset), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_ctrl(in_ctrl), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_ctrl(out_ctrl), .out_data(out_data),
        .cnt_clear(cnt_clear), .stall_cnt(stall_cnt), .bubble_cnt(bubble_cnt), .flush_cnt(flush_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [DATA_W-1:0] d);
        in_valid = v;
        in_data  = d;
        in_ctrl  = d[7:0] ^ 8'h3C;
    endtask

    task automatic clear_counters();
        cnt_clear = 1'b1;
        tick();
        cnt_clear = 1'b0;
    endtask

    // Scoreboard: pop and compare on out_fire, then discard on reset/flush or push on in_fire.
    always @(negedge clk) begin
        if (reset) begin
            sb_q.delete();
        end else begin
            if (out_valid === 1'b1 && out_ready === 1'b1) begin
                if (sb_q.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL sb_unexpected: got %0h expected none", {out_ctrl, out_data});
                end else begin
                    check("sb_order", {8'h00, out_ctrl, out_data}, {8'h00, sb_q.pop_front()});
                end
            end
            if (flush) begin
                sb_q.delete();
            end else if (in_valid === 1'b1 && in_ready === 1'b1) begin
                sb_q.push_back({in_ctrl, in_data});
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        // 1. Reset, then stream four instructions at full rate
        tick();
        tick();
        reset = 1'b0;
        check("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("rst_out_ctrl", {24'd0, out_ctrl}, {24'd0, CTRL_NOP});
        check("rst_out_data", {16'd0, out_data}, 32'd0);
        check("rst_in_ready", {31'd0, in_ready}, 32'd1);
        check("rst_counters", {20'd0, stall_cnt, bubble_cnt, flush_cnt}, 32'd0);
        out_ready = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            drive(1'b1, i[15:0]);
            tick();
            check("stream_in_ready", {31'd0, in_ready}, 32'd1);
            check("stream_out_valid", {31'd0, out_valid}, 32'd1);
            check("stream_out_data", {16'd0, out_data}, i);
        end
        drive(1'b0, 16'h0000);
        tick();
        check("stream_drained", {31'd0, out_valid}, 32'd0);
        check("stream_stall_cnt", {28'd0, stall_cnt}, 32'd0);

        // 2. Backpressure fills the skid entry
        clear_counters();
        drive(1'b1, 16'h00A0);
        tick();
        out_ready = 1'b0;
        drive(1'b1, 16'h00B0);
        tick();
        check("skid_in_ready", {31'd0, in_ready}, 32'd0);
        check("skid_hold_A", {16'd0, out_data}, 32'h00A0);
        drive(1'b1, 16'h00C0);
        tick();
        tick();
        check("skid_still_A", {16'd0, out_data}, 32'h00A0);
        check("skid_in_ready2", {31'd0, in_ready}, 32'd0);
        out_ready = 1'b1;
        tick();
        check("skid_out_B", {16'd0, out_data}, 32'h00B0);
        check("skid_ready_back", {31'd0, in_ready}, 32'd1);
        tick();
        drive(1'b0, 16'h0000);
        check("skid_out_C", {16'd0, out_data}, 32'h00C0);
        tick();
        check("skid_empty", {31'd0, out_valid}, 32'd0);
        check("skid_stall_cnt", {28'd0, stall_cnt}, 32'd3);

        // 3. Flush while holding two entries
        clear_counters();
        out_ready = 1'b0;
        drive(1'b1, 16'h0A0A);
        tick();
        drive(1'b1, 16'h0B0B);
        tick();
        drive(1'b1, 16'h0D0D);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        drive(1'b0, 16'h0000);
        check("flush_out_valid", {31'd0, out_valid}, 32'd0);
        check("flush_out_ctrl", {24'd0, out_ctrl}, {24'd0, CTRL_NOP});
        check("flush_out_data", {16'd0, out_data}, 32'd0);
        check("flush_in_ready", {31'd0, in_ready}, 32'd1);
        check("flush_cnt1", {28'd0, flush_cnt}, 32'd1);
        out_ready = 1'b1;
        tick();
        check("flush_no_D", {31'd0, out_valid}, 32'd0);
        // An instruction accepted during a flush is dropped
        drive(1'b1, 16'h0E0E);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        drive(1'b0, 16'h0000);
        check("flush_drop_in", {31'd0, out_valid}, 32'd0);
        check("flush_cnt2", {28'd0, flush_cnt}, 32'd2);

        // 4. Accept and emit in the same cycle while holding one entry
        out_ready = 1'b0;
        drive(1'b1, 16'h1111);
        tick();
        out_ready = 1'b1;
        drive(1'b1, 16'h2222);
        tick();
        drive(1'b0, 16'h0000);
        check("pass_out_Y", {16'd0, out_data}, 32'h2222);
        check("pass_ctrl_Y", {24'd0, out_ctrl}, {24'd0, 8'h22 ^ 8'h3C});
        check("pass_in_ready", {31'd0, in_ready}, 32'd1);
        tick();
        check("pass_empty", {31'd0, out_valid}, 32'd0);

        // 5. bubble_cnt saturates, and a simultaneous flush and clear leaves flush_cnt at zero
        clear_counters();
        for (int i = 1; i <= 20; i++) begin
            tick();
            if (i == 14) check("bub_14", {28'd0, bubble_cnt}, 32'd14);
            if (i == 15) check("bub_15", {28'd0, bubble_cnt}, 32'd15);
        end
        check("bub_sat", {28'd0, bubble_cnt}, 32'd15);
        cnt_clear = 1'b1;
        flush = 1'b1;
        tick();
        cnt_clear = 1'b0;
        flush = 1'b0;
        check("bub_clear", {28'd0, bubble_cnt}, 32'd0);
        check("flush_clear", {28'd0, flush_cnt}, 32'd0);

        // 6. Reset while holding two entries
        out_ready = 1'b0;
        drive(1'b1, 16'h3333);
        tick();
        drive(1'b1, 16'h4444);
        tick();
        drive(1'b0, 16'h0000);
        tick();
        check("pre_rst_stall", {28'd0, stall_cnt}, 32'd2);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("mid_rst_valid", {31'd0, out_valid}, 32'd0);
        check("mid_rst_ready", {31'd0, in_ready}, 32'd1);
        check("mid_rst_cnts", {20'd0, stall_cnt, bubble_cnt, flush_cnt}, 32'd0);
        out_ready = 1'b1;
        tick();
        tick();
        check("mid_rst_gone", {31'd0, out_valid}, 32'd0);
        check("sb_empty", sb_q.size(), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
